depar_seg_gather: RTL

DEPAR_SEG_GATHER -- requirements
Module: depar_seg_gather

---
 rtl/depar_seg_gather.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/depar_seg_gather.sv
// ============================================================================
// Module   : depar_seg_gather
// Purpose  : Gathers the first C_NUM_SEGS header segments of each packet from
//            a first-word-fall-through FIFO into groups of C_SEGS_PER_GROUP
//            slots. Each group is pulsed out as soon as it is complete.
//            Segments beyond C_NUM_SEGS stream straight through to a
//            remainder FIFO.
// Option   : `define DEPAR_VLAN_EXTRACT_EN to register the VLAN ID taken from
//            segment 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module depar_seg_gather #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 4,
  parameter int C_SEGS_PER_GROUP   = 2,
  parameter int C_VLAN_OFFSET      = 116
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]                    pkt_fifo_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]                   pkt_fifo_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]                  pkt_fifo_tkeep,
  input  logic                                            pkt_fifo_tlast,
  input  logic                                            pkt_fifo_empty,
  output logic                                            pkt_fifo_rd_en,
  input  logic [C_NUM_SEGS/C_SEGS_PER_GROUP-1:0]          grp_ready,
  output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]         grp_tdata,
  output logic [C_NUM_SEGS*C_AXIS_TUSER_WIDTH-1:0]        grp_tuser,
  output logic [C_NUM_SEGS*(C_AXIS_DATA_WIDTH/8)-1:0]     grp_tkeep,
  output logic [C_NUM_SEGS-1:0]                           grp_tlast,
  output logic [C_NUM_SEGS/C_SEGS_PER_GROUP-1:0]          grp_valid,
  output logic [3:0]                                      seg_cnt,
  output logic [11:0]                                     vlan,
  output logic                                            vlan_valid,
  output logic [C_AXIS_DATA_WIDTH-1:0]                    output_fifo_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                   output_fifo_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                  output_fifo_tkeep,
  output logic                                            output_fifo_tlast,
  output logic                                            output_fifo_valid,
  input  logic                                            output_fifo_ready
);

  localparam int DW  = C_AXIS_DATA_WIDTH;
  localparam int UW  = C_AXIS_TUSER_WIDTH;
  localparam int KW  = C_AXIS_DATA_WIDTH / 8;
  localparam int NS  = C_NUM_SEGS;
  localparam int SPG = C_SEGS_PER_GROUP;
  localparam int NG  = C_NUM_SEGS / C_SEGS_PER_GROUP;

  // Reject parameter sets the slot/group arithmetic cannot handle
  if ((NS % SPG) != 0 || NS < 2 || NS > 8 || (C_VLAN_OFFSET + 12) > DW) begin : g_param_check
    $error("depar_seg_gather: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    S_CAPTURE = 1'b0,
    S_FLUSH   = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [3:0]      r_seg_cnt, w_seg_cnt_nxt;
  logic [NG-1:0]   r_grp_valid, w_pulse;
  logic [NG-1:0]   w_mask;       // groups at or above the current group
  logic [NG-1:0]   w_sel;        // one-hot of the current group
  logic [3:0]      w_g;
  logic            w_last_in_grp, w_last_slot, w_all_ready, w_grp_rdy;
  logic            w_pop, w_wr, w_clear;

  assign w_g           = 4'(32'(r_idx) / SPG);
  assign w_last_in_grp = ((32'(r_idx) % SPG) == (SPG - 1));
  assign w_last_slot   = (32'(r_idx) == (NS - 1));

  for (genvar k = 0; k < NG; k++) begin : g_grp_mask
    assign w_mask[k] = (32'(k) >= 32'(w_g));
    assign w_sel[k]  = (32'(k) == 32'(w_g));
  end

  // A tlast head closes every group from the current one upward, so all of them must be ready
  assign w_all_ready = &(grp_ready | ~w_mask);
  assign w_grp_rdy   = |(grp_ready & w_sel);

  // Next-state, pop decision and remainder-FIFO drive
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_seg_cnt_nxt     = r_seg_cnt;
    w_pulse           = '0;
    w_pop             = 1'b0;
    w_wr              = 1'b0;
    w_clear           = 1'b0;
    output_fifo_tdata = '0;
    output_fifo_tuser = '0;
    output_fifo_tkeep = '0;
    output_fifo_tlast = 1'b0;
    output_fifo_valid = 1'b0;
    if (!rst) begin
      case (r_state)
        S_CAPTURE: begin
          if (!pkt_fifo_empty) begin
            w_wr = 1'b1;
            if (pkt_fifo_tlast) begin
              if (w_all_ready) begin
                w_pop         = 1'b1;
                w_pulse       = w_mask;
                w_clear       = 1'b1;
                w_seg_cnt_nxt = 4'(r_idx) + 4'd1;
                w_idx_nxt     = '0;
              end
            end else if (!w_last_in_grp) begin
              w_pop     = 1'b1;
              w_idx_nxt = r_idx + 3'd1;
            end else if (w_grp_rdy) begin
              w_pop   = 1'b1;
              w_pulse = w_sel;
              if (w_last_slot) begin
                w_state_nxt   = S_FLUSH;
                w_idx_nxt     = '0;
                w_seg_cnt_nxt = 4'(NS);
              end else begin
                w_idx_nxt = r_idx + 3'd1;
              end
            end
          end
        end
        S_FLUSH: begin
          if (!pkt_fifo_empty && output_fifo_ready) begin
            w_pop             = 1'b1;
            output_fifo_tdata = pkt_fifo_tdata;
            output_fifo_tuser = pkt_fifo_tuser;
            output_fifo_tkeep = pkt_fifo_tkeep;
            output_fifo_tlast = pkt_fifo_tlast;
            output_fifo_valid = 1'b1;
            if (pkt_fifo_tlast) begin
              w_state_nxt = S_CAPTURE;
            end
          end
        end
      endcase
    end
  end

  assign pkt_fifo_rd_en = w_pop;

  // State, slot index, group pulses and segment count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CAPTURE;
      r_idx       <= '0;
      r_seg_cnt   <= '0;
      r_grp_valid <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_seg_cnt   <= w_seg_cnt_nxt;
      r_grp_valid <= w_pulse;
    end
  end

  assign grp_valid = r_grp_valid;
  assign seg_cnt   = r_seg_cnt;

  for (genvar s = 0; s < NS; s++) begin : g_slot
    logic [DW-1:0] r_tdata;
    logic [UW-1:0] r_tuser;
    logic [KW-1:0] r_tkeep;
    logic          r_tlast;

    // Capture the head into this slot; slots past a short packet's end are marked empty
    always_ff @(posedge clk) begin
      if (rst) begin
        r_tdata <= '0;
        r_tuser <= '0;
        r_tkeep <= '0;
        r_tlast <= 1'b0;
      end else if (w_wr && (32'(r_idx) == 32'(s))) begin
        r_tdata <= pkt_fifo_tdata;
        r_tuser <= pkt_fifo_tuser;
        r_tkeep <= pkt_fifo_tkeep;
        r_tlast <= pkt_fifo_tlast;
      end else if (w_clear && (32'(s) > 32'(r_idx))) begin
        r_tkeep <= '0;
        r_tlast <= 1'b0;
      end
    end

    assign grp_tdata[s*DW +: DW] = r_tdata;
    assign grp_tuser[s*UW +: UW] = r_tuser;
    assign grp_tkeep[s*KW +: KW] = r_tkeep;
    assign grp_tlast[s]          = r_tlast;
  end

`ifdef DEPAR_VLAN_EXTRACT_EN
  logic [11:0] r_vlan;
  logic        r_vlan_valid;
  logic        w_vlan_load;

  assign w_vlan_load = w_pop && (r_state == S_CAPTURE) && (r_idx == 3'd0);

  // Latch the VLAN ID whenever segment 0 actually leaves the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vlan       <= '0;
      r_vlan_valid <= 1'b0;
    end else begin
      r_vlan_valid <= w_vlan_load;
      if (w_vlan_load) begin
        r_vlan <= pkt_fifo_tdata[C_VLAN_OFFSET +: 12];
      end
    end
  end

  assign vlan       = r_vlan;
  assign vlan_valid = r_vlan_valid;
`else
  assign vlan       = '0;
  assign vlan_valid = 1'b0;
`endif

endmodule

`default_nettype wire
